// File: rtl/qsys_basic_pio_in_mc.sv
// Multi-channel Avalon-MM input port: synchronised channel inputs, freeze/snapshot
// holding registers, per-channel W1C change flags and a maskable level interrupt.
module qsys_basic_pio_in_mc #(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [3:0]               address,
  input  logic                     read,
  input  logic                     write,
  input  logic [31:0]              writedata,
  output logic [31:0]              readdata,
  input  logic [NUM_CH*DATA_W-1:0] in_port,
  output logic                     irq
);

  localparam int         IN_W        = NUM_CH * DATA_W;
  localparam logic [3:0] ADDR_STATUS = 4'h8;
  localparam logic [3:0] ADDR_MASK   = 4'h9;
  localparam logic [3:0] ADDR_CTRL   = 4'hA;

  logic [SYNC_STAGES-1:0][IN_W-1:0] sync_q;
  logic [IN_W-1:0]                  sync_s;
  logic [IN_W-1:0]                  ch_q;
  logic [IN_W-1:0]                  ch_d;
  logic [NUM_CH-1:0]                status_q;
  logic [NUM_CH-1:0]                status_d;
  logic [NUM_CH-1:0]                mask_q;
  logic [NUM_CH-1:0]                mask_d;
  logic [NUM_CH-1:0]                set_s;
  logic [NUM_CH-1:0]                clr_s;
  logic                             freeze_q;
  logic                             freeze_d;
  logic                             snap_s;
  logic                             load_s;
  logic [DATA_W-1:0]                ch_sel_s;
  logic [31:0]                      readdata_q;
  logic [31:0]                      readdata_d;
  logic                             unused_s;

  // read strobe is informational; upper writedata bits are not stored anywhere
  assign unused_s = ^{read, writedata};
  assign sync_s   = sync_q[SYNC_STAGES-1];

  // Input synchroniser chain, one shift per cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  // Hold-register load, change detection and register-write next state
  always_comb begin
    snap_s   = write && (address == ADDR_CTRL) && writedata[1];
    load_s   = !freeze_q || snap_s;
    ch_d     = ch_q;
    set_s    = '0;
    clr_s    = '0;
    mask_d   = mask_q;
    freeze_d = freeze_q;
    if (load_s) begin
      ch_d = sync_s;
    end else begin
      ch_d = ch_q;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      set_s[i] = load_s && (sync_s[i*DATA_W +: DATA_W] != ch_q[i*DATA_W +: DATA_W]);
    end
    if (write && (address == ADDR_STATUS)) begin
      clr_s = writedata[NUM_CH-1:0];
    end else begin
      clr_s = '0;
    end
    if (write && (address == ADDR_MASK)) begin
      mask_d = writedata[NUM_CH-1:0];
    end else begin
      mask_d = mask_q;
    end
    if (write && (address == ADDR_CTRL)) begin
      freeze_d = writedata[0];
    end else begin
      freeze_d = freeze_q;
    end
    // a new change in the same cycle as its clear must survive
    status_d = (status_q & ~clr_s) | set_s;
  end

  // Read mux; channel slots beyond NUM_CH and reserved words return zero
  always_comb begin
    readdata_d = 32'd0;
    ch_sel_s   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_sel_s = ch_sel_s | ({DATA_W{address == 4'(i)}} & ch_q[i*DATA_W +: DATA_W]);
    end
    case (address)
      ADDR_STATUS: readdata_d[NUM_CH-1:0] = status_q;
      ADDR_MASK:   readdata_d[NUM_CH-1:0] = mask_q;
      ADDR_CTRL:   readdata_d[0]          = freeze_q;
      default: begin
        if (address[3] == 1'b0) begin
          readdata_d[DATA_W-1:0] = ch_sel_s;
        end else begin
          readdata_d = 32'd0;
        end
      end
    endcase
  end

  // Architectural registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ch_q       <= '0;
      status_q   <= '0;
      mask_q     <= '0;
      freeze_q   <= 1'b0;
      readdata_q <= 32'd0;
    end else begin
      ch_q       <= ch_d;
      status_q   <= status_d;
      mask_q     <= mask_d;
      freeze_q   <= freeze_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(status_q & mask_q);

endmodule

// File: tb/tb_qsys_basic_pio_in_mc.sv
// Scoreboard bench for qsys_basic_pio_in_mc: stimulus queues expected readdata/irq
// values, a monitor pops and compares them when a read or irq probe is presented.
module tb_qsys_basic_pio_in_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  address = 4'h0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic [31:0] readdata;
  logic [47:0] in_port = 48'd0;
  logic        irq;
  logic        irq_chk = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_exp_q[$];
  string       rd_name_q[$];
  logic        irq_exp_q[$];
  string       irq_name_q[$];
  bit          rd_fire;
  bit          irq_fire;
  event        imm_ev;

  qsys_basic_pio_in_mc #(.NUM_CH(4), .DATA_W(12), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .in_port(in_port), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check_rd();
    logic [31:0] e;
    string n;
    checks++;
    if (rd_exp_q.size() == 0) begin
      errors++;
      $display("FAIL rd_underflow: readdata 0x%0h with no expectation queued", readdata);
    end else begin
      e = rd_exp_q.pop_front();
      n = rd_name_q.pop_front();
      if (readdata !== e) begin
        errors++;
        $display("FAIL %s: readdata got 0x%0h expected 0x%0h", n, readdata, e);
      end
    end
  endtask

  task automatic check_irq();
    logic e;
    string n;
    checks++;
    if (irq_exp_q.size() == 0) begin
      errors++;
      $display("FAIL irq_underflow: irq %0b with no expectation queued", irq);
    end else begin
      e = irq_exp_q.pop_front();
      n = irq_name_q.pop_front();
      if (irq !== e) begin
        errors++;
        $display("FAIL %s: irq got %0b expected %0b", n, irq, e);
      end
    end
  endtask

  // Monitor: a read or irq probe presented at an edge is checked 1 time unit later
  always @(posedge clk) begin
    rd_fire  = read;
    irq_fire = irq_chk;
    #1;
    if (rd_fire) check_rd();
    if (irq_fire) check_irq();
  end

  // Monitor: immediate checks requested between clock edges
  always @(imm_ev) begin
    check_rd();
    check_irq();
  end

  task automatic step();
    @(negedge clk);
    read      = 1'b0;
    write     = 1'b0;
    irq_chk   = 1'b0;
    writedata = 32'd0;
  endtask

  task automatic rd_now(input logic [3:0] a, input logic [31:0] e, input string n);
    address = a;
    read    = 1'b1;
    rd_exp_q.push_back(e);
    rd_name_q.push_back(n);
  endtask

  task automatic wr_now(input logic [3:0] a, input logic [31:0] d);
    address   = a;
    write     = 1'b1;
    writedata = d;
  endtask

  task automatic irq_now(input logic e, input string n);
    irq_chk = 1'b1;
    irq_exp_q.push_back(e);
    irq_name_q.push_back(n);
  endtask

  task automatic set_ch(input int c, input logic [11:0] v);
    in_port[c*12 +: 12] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    #3;
    rd_exp_q.push_back(32'd0);  rd_name_q.push_back("reset_readdata");
    irq_exp_q.push_back(1'b0);  irq_name_q.push_back("reset_irq");
    -> imm_ev;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      rd_now(4'h0, 32'd0, "idle_rd");
      irq_now(1'b0, "idle_irq");
      step();
    end
    rd_now(4'h8, 32'd0, "idle_status"); step();

    // Channel sweep
    set_ch(0, 12'hABC);
    set_ch(3, 12'hFFF);
    repeat (3) step();
    rd_now(4'h0, 32'h0000_0ABC, "sweep_ch0");    step();
    rd_now(4'h3, 32'h0000_0FFF, "sweep_ch3");    step();
    rd_now(4'h5, 32'd0,         "sweep_ch5");    step();
    rd_now(4'h8, 32'h0000_0009, "sweep_status"); step();
    wr_now(4'h8, 32'h0000_000F); step();

    // Synchroniser latency: visible on readdata exactly three edges later
    set_ch(1, 12'h123);
    rd_now(4'h1, 32'd0, "lat_k");    step();
    rd_now(4'h1, 32'd0, "lat_k1");   step();
    rd_now(4'h1, 32'd0, "lat_k2");   step();
    rd_now(4'h1, 32'h123, "lat_k3"); step();

    // Interrupt and W1C
    wr_now(4'h8, 32'h0000_000F); step();
    wr_now(4'h9, 32'h0000_0002); irq_now(1'b0, "irq_mask_only"); step();
    set_ch(1, 12'h456);
    irq_now(1'b0, "irq_k");  step();
    irq_now(1'b0, "irq_k1"); step();
    irq_now(1'b1, "irq_k2"); step();
    wr_now(4'h8, 32'h0000_0001); irq_now(1'b1, "irq_clr_other"); step();
    wr_now(4'h8, 32'h0000_0002); irq_now(1'b0, "irq_clr_own");   step();
    rd_now(4'h8, 32'd0, "status_after_clr"); step();
    set_ch(1, 12'h789);
    step();
    step();
    wr_now(4'h8, 32'h0000_0002); irq_now(1'b1, "set_wins_irq"); step();
    rd_now(4'h8, 32'h0000_0002, "set_wins_status"); step();
    wr_now(4'h8, 32'h0000_0002); irq_now(1'b0, "irq_final_clr"); step();

    // Freeze / snapshot
    wr_now(4'hA, 32'h0000_0001); step();
    set_ch(2, 12'h055);
    repeat (4) step();
    rd_now(4'h2, 32'd0,   "frz_ch2_held");   step();
    rd_now(4'h8, 32'd0,   "frz_status");     step();
    rd_now(4'h1, 32'h789, "frz_ch1");        step();
    wr_now(4'h0, 32'h0000_0FFF); step();
    rd_now(4'h0, 32'hABC, "ch_write_ignored"); step();
    wr_now(4'hB, 32'hFFFF_FFFF); step();
    rd_now(4'hB, 32'd0,   "reserved_rd");    step();
    wr_now(4'h9, 32'h0000_00FF); step();
    rd_now(4'h9, 32'h0000_000F, "mask_width"); step();
    wr_now(4'h9, 32'd0); step();
    wr_now(4'hA, 32'h0000_0003); step();
    rd_now(4'h2, 32'h055, "snap_ch2");       step();
    rd_now(4'h8, 32'h0000_0004, "snap_status"); step();
    rd_now(4'hA, 32'h0000_0001, "ctrl_rb");  step();

    // Build STATUS = 0xF, MASK = 0xF, then asynchronous reset between edges
    set_ch(0, 12'h001);
    set_ch(1, 12'h002);
    set_ch(2, 12'h003);
    set_ch(3, 12'h004);
    repeat (3) step();
    wr_now(4'hA, 32'h0000_0003); step();
    wr_now(4'h9, 32'h0000_000F); irq_now(1'b1, "pre_rst_irq"); step();
    rd_now(4'h8, 32'h0000_000F, "pre_rst_status"); step();
    #2 reset = 1'b1;
    #1;
    rd_exp_q.push_back(32'd0);  rd_name_q.push_back("async_rst_readdata");
    irq_exp_q.push_back(1'b0);  irq_name_q.push_back("async_rst_irq");
    -> imm_ev;
    reset = 1'b0;
    rd_now(4'h8, 32'd0, "post_rst_status"); step();
    rd_now(4'h0, 32'd0, "post_rst_ch0");    step();
    rd_now(4'h9, 32'd0, "post_rst_mask");   step();
    rd_now(4'hA, 32'd0, "post_rst_ctrl");   step();
    rd_now(4'h8, 32'h0000_000F, "post_rst_flags"); irq_now(1'b0, "post_rst_irq"); step();
    rd_now(4'h0, 32'h001, "post_rst_ch0_new"); step();
    step();
    step();

    checks++;
    if (rd_exp_q.size() != 0 || irq_exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: %0d readdata and %0d irq expectations never checked",
               rd_exp_q.size(), irq_exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
